status_flags_unit: RTL and testbench

- Parametrised successor to the fixed 8-bit czonGLEN status register and its gated flags clock in the CPU.
- Holds FLAG_WIDTH ALU flags and evaluates the instruction's condition into _do_exec.
- Latches new flags only for executed instructions that request a flag update.
- Adds a STACK_DEPTH-entry flag save/restore stack for interrupt and call entry, with overflow/underflow error reporting.

---
 rtl/status_flags_unit.sv | 130 +++++++++++++
 tb/tb_status_flags_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_flags_unit.sv
// status_flags_unit: parametrised CPU status register with condition
// evaluation, masked flag update and a LIFO flag save/restore stack.
// Outputs flags_q, sp and the error bits are registered; _do_exec,
// carry_in, stk_empty and stk_full are combinational from that state.
// There is no handshake: every request is a level sampled at posedge clk
// and only acts while exec_phase is high (error clear excepted).
module status_flags_unit #(
  parameter int                      FLAG_WIDTH  = 8,
  parameter int                      STACK_DEPTH = 4,
  parameter logic [FLAG_WIDTH-1:0]   UPDATE_MASK = {FLAG_WIDTH{1'b1}},
  parameter logic [FLAG_WIDTH-1:0]   RESET_VAL   = {FLAG_WIDTH{1'b0}},
  parameter int                      CARRY_BIT   = FLAG_WIDTH - 1
) (
  input  logic                                 clk,
  input  logic                                 _mr,
  input  logic                                 exec_phase,
  input  logic [FLAG_WIDTH-1:0]                alu_flags,
  input  logic                                 _set_flags,
  input  logic [$clog2(FLAG_WIDTH+1)-1:0]      cond_idx,
  input  logic                                 cond_inv,
  input  logic                                 _push,
  input  logic                                 _pop,
  input  logic                                 _clr_err,
  output logic [FLAG_WIDTH-1:0]                flags_q,
  output logic                                 carry_in,
  output logic                                 _do_exec,
  output logic [$clog2(STACK_DEPTH):0]         sp,
  output logic                                 stk_empty,
  output logic                                 stk_full,
  output logic                                 err_ovf,
  output logic                                 err_unf
);

  localparam int CW  = $clog2(FLAG_WIDTH + 1);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  logic [FLAG_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [FLAG_WIDTH-1:0] flags_d;
  logic [SPW-1:0]        sp_q;
  logic [SPW-1:0]        sp_dec;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  cond_sel;
  logic                  exec_hi;
  logic                  push_req;
  logic                  pop_req;
  logic                  upd_req;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_set;
  logic                  unf_set;

  assign sp        = sp_q;
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
  assign carry_in  = flags_q[CARRY_BIT];
  assign _do_exec  = ~exec_hi;

  // Select the flag named by cond_idx (1-based); out-of-range selects nothing.
  always_comb begin
    cond_sel = 1'b0;
    for (int k = 0; k < FLAG_WIDTH; k++) begin
      if (cond_idx == CW'(k + 1)) cond_sel = flags_q[k];
    end
  end

  // Condition result: 0 always executes, beyond FLAG_WIDTH never executes.
  always_comb begin
    if (cond_idx == '0)                      exec_hi = 1'b1;
    else if (cond_idx <= CW'(FLAG_WIDTH))    exec_hi = cond_sel ^ cond_inv;
    else                                     exec_hi = 1'b0;
  end

  // Request decode; push/pop are gated by exec_phase only, not by the condition.
  assign push_req = exec_phase & ~_push;
  assign pop_req  = exec_phase & ~_pop;
  assign upd_req  = exec_phase & ~_set_flags & exec_hi;
  assign push_ok  = push_req & ~pop_req & ~stk_full;
  assign pop_ok   = pop_req & ~push_req & ~stk_empty;
  assign ovf_set  = push_req & (stk_full | pop_req);
  assign unf_set  = pop_req & (stk_empty | push_req);
  assign sp_dec   = sp_q - SPW'(1);
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = sp_dec[AW-1:0];

  // Next flags: masked ALU update, overridden by a successful pop.
  always_comb begin
    flags_d = flags_q;
    if (upd_req) flags_d = (alu_flags & UPDATE_MASK) | (flags_q & ~UPDATE_MASK);
    if (pop_ok)  flags_d = stack_q[rd_idx];
  end

  // Status register.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) flags_q <= RESET_VAL;
    else      flags_q <= flags_d;
  end

  // Stack storage; a push saves the pre-update flags value.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push_ok) begin
      stack_q[wr_idx] <= flags_q;
    end
  end

  // Stack pointer, saturating at 0 and STACK_DEPTH.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr)         sp_q <= '0;
    else if (push_ok) sp_q <= sp_q + SPW'(1);
    else if (pop_ok)  sp_q <= sp_dec;
  end

  // Sticky overflow error; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr)           err_ovf <= 1'b0;
    else if (ovf_set)   err_ovf <= 1'b1;
    else if (!_clr_err) err_ovf <= 1'b0;
  end

  // Sticky underflow error; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr)           err_unf <= 1'b0;
    else if (unf_set)   err_unf <= 1'b1;
    else if (!_clr_err) err_unf <= 1'b0;
  end

endmodule

// File: tb/tb_status_flags_unit.sv
// Bench for status_flags_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_status_flags_unit;

  localparam int FW = 8;
  localparam int SD = 4;
  localparam logic [FW-1:0] MASK = 8'hFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          _mr;
  logic          exec_phase;
  logic [FW-1:0] alu_flags;
  logic          _set_flags;
  logic [3:0]    cond_idx;
  logic          cond_inv;
  logic          _push;
  logic          _pop;
  logic          _clr_err;
  logic [FW-1:0] flags_q;
  logic          carry_in;
  logic          _do_exec;
  logic [2:0]    sp;
  logic          stk_empty;
  logic          stk_full;
  logic          err_ovf;
  logic          err_unf;

  status_flags_unit #(.FLAG_WIDTH(FW), .STACK_DEPTH(SD)) dut (
    .clk(clk), ._mr(_mr), .exec_phase(exec_phase), .alu_flags(alu_flags),
    ._set_flags(_set_flags), .cond_idx(cond_idx), .cond_inv(cond_inv),
    ._push(_push), ._pop(_pop), ._clr_err(_clr_err), .flags_q(flags_q),
    .carry_in(carry_in), ._do_exec(_do_exec), .sp(sp), .stk_empty(stk_empty),
    .stk_full(stk_full), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [FW-1:0] m_flags;
  logic [FW-1:0] exp_q[$];   // model stack, back = top
  logic          m_ovf;
  logic          m_unf;
  bit            chk_en = 0;

  function automatic logic m_exec();
    int k;
    k = int'(cond_idx);
    if (k == 0) return 1'b1;
    if (k > FW) return 1'b0;
    return m_flags[k-1] ^ cond_inv;
  endfunction

  task automatic m_reset();
    m_flags = '0;
    exp_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Model one rising edge from the current inputs.
  task automatic m_step();
    logic p, q, u;
    logic [FW-1:0] nf;
    if (!_mr) return;
    p  = exec_phase && !_push;
    q  = exec_phase && !_pop;
    u  = exec_phase && !_set_flags && m_exec();
    nf = u ? ((alu_flags & MASK) | (m_flags & ~MASK)) : m_flags;
    if (!_clr_err) begin m_ovf = 0; m_unf = 0; end
    if (p && q) begin
      m_ovf = 1; m_unf = 1;
    end else if (p) begin
      if (exp_q.size() < SD) exp_q.push_back(m_flags);
      else m_ovf = 1;
    end else if (q) begin
      if (exp_q.size() > 0) nf = exp_q.pop_back();
      else m_unf = 1;
    end
    m_flags = nf;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all outputs against the model once per cycle.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("flags_q",   32'(flags_q),   32'(m_flags));
      chk("carry_in",  32'(carry_in),  32'(m_flags[FW-1]));
      chk("_do_exec",  32'(_do_exec),  32'(!m_exec()));
      chk("sp",        32'(sp),        32'(exp_q.size()));
      chk("stk_empty", 32'(stk_empty), 32'(exp_q.size() == 0));
      chk("stk_full",  32'(stk_full),  32'(exp_q.size() == SD));
      chk("err_ovf",   32'(err_ovf),   32'(m_ovf));
      chk("err_unf",   32'(err_unf),   32'(m_unf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    exec_phase = 0; alu_flags = '0; _set_flags = 1; cond_idx = '0;
    cond_inv = 0; _push = 1; _pop = 1; _clr_err = 1;
  endtask

  // Apply current inputs across one rising edge; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic exec_op(input logic [FW-1:0] alu, input logic set_n,
                         input logic push_n, input logic pop_n);
    idle();
    exec_phase = 1; alu_flags = alu; _set_flags = set_n; _push = push_n; _pop = pop_n;
    cycle();
    idle();
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    _mr = 0;
    m_reset();
    chk_en = 1;
    #1000;
    chk("rst flags_q",   32'(flags_q),   32'h00);
    chk("rst sp",        32'(sp),        32'd0);
    chk("rst stk_empty", 32'(stk_empty), 32'd1);
    chk("rst _do_exec",  32'(_do_exec),  32'd0);
    @(negedge clk);
    _mr = 1;

    exec_op(8'b00111010, 0, 1, 1);
    chk("load flags", 32'(flags_q), 32'h3A);
    chk("load carry", 32'(carry_in), 32'd0);

    for (int i = 0; i < 3; i++) exec_op(8'hFF, 1, 1, 1);
    chk("hold flags", 32'(flags_q), 32'h3A);
    exec_op(8'b11111010, 0, 1, 1);
    chk("upd flags", 32'(flags_q), 32'hFA);
    chk("upd carry", 32'(carry_in), 32'd1);

    exec_op(8'b11101010, 0, 1, 1);
    cond_idx = 4'd8; cond_inv = 1; #1;
    chk("cond inv skip", 32'(_do_exec), 32'd1);
    @(negedge clk);
    exec_phase = 1; _set_flags = 0; alu_flags = 8'h00; cond_idx = 4'd8; cond_inv = 1;
    cycle(); idle(); #2;
    chk("skipped no upd", 32'(flags_q), 32'hEA);
    cond_idx = 4'd8; cond_inv = 0; #1;
    chk("cond exec", 32'(_do_exec), 32'd0);
    @(negedge clk);
    exec_phase = 1; _set_flags = 0; alu_flags = 8'h00; cond_idx = 4'd8; cond_inv = 0;
    cycle(); idle(); #2;
    chk("exec upd", 32'(flags_q), 32'h00);

    // Push 01,02,04,08 (each push saves the pre-update value).
    exec_op(8'h01, 0, 1, 1);
    exec_op(8'h02, 0, 0, 1);
    exec_op(8'h04, 0, 0, 1);
    exec_op(8'h08, 0, 0, 1);
    exec_op(8'h00, 1, 0, 1);
    chk("full sp",   32'(sp),       32'd4);
    chk("full flag", 32'(stk_full), 32'd1);
    exec_op(8'h00, 1, 0, 1);
    chk("ovf err", 32'(err_ovf), 32'd1);
    chk("ovf sp",  32'(sp),      32'd4);
    exec_op(8'h00, 1, 1, 0); chk("pop1", 32'(flags_q), 32'h08);
    exec_op(8'h00, 1, 1, 0); chk("pop2", 32'(flags_q), 32'h04);
    exec_op(8'h00, 1, 1, 0); chk("pop3", 32'(flags_q), 32'h02);
    exec_op(8'h00, 1, 1, 0); chk("pop4", 32'(flags_q), 32'h01);
    exec_op(8'h00, 1, 1, 0);
    chk("unf err",   32'(err_unf), 32'd1);
    chk("unf flags", 32'(flags_q), 32'h01);

    // Error clear outside exec phase, pop overrides update, push+pop collision.
    _clr_err = 0; cycle(); idle(); #2;
    chk("clr ovf", 32'(err_ovf), 32'd0);
    exec_op(8'h55, 0, 1, 1);
    exec_op(8'h00, 1, 0, 1);
    exec_op(8'hAA, 0, 1, 0);
    chk("pop beats upd", 32'(flags_q), 32'h55);
    exec_op(8'h00, 1, 0, 1);
    exec_op(8'h00, 1, 0, 0);
    chk("pp sp",  32'(sp),      32'd1);
    chk("pp ovf", 32'(err_ovf), 32'd1);
    chk("pp unf", 32'(err_unf), 32'd1);
    _clr_err = 0; cycle(); idle(); #2;
    chk("clr both", 32'({err_ovf, err_unf}), 32'd0);

    // Asynchronous reset mid-exec after two pushes.
    exec_op(8'h00, 1, 0, 1);
    exec_op(8'h00, 1, 0, 1);
    exec_phase = 1; _push = 0;
    #2;
    _mr = 0;
    m_reset();
    #1;
    chk("async flags", 32'(flags_q), 32'h00);
    chk("async sp",    32'(sp),      32'd0);
    chk("async errs",  32'({err_ovf, err_unf}), 32'd0);
    cycle();
    idle();
    _mr = 1;
    exec_op(8'h00, 1, 1, 0);
    chk("pop after rst", 32'(err_unf), 32'd1);

    // Random traffic checked by the compare process.
    for (int n = 0; n < 600; n++) begin
      exec_phase = ($urandom_range(0, 3) != 0);
      alu_flags  = FW'($urandom_range(0, 255));
      _set_flags = $urandom_range(0, 1) != 0;
      cond_idx   = 4'($urandom_range(0, 15));
      cond_inv   = $urandom_range(0, 1) != 0;
      _push      = ($urandom_range(0, 2) != 0);
      _pop       = ($urandom_range(0, 2) != 0);
      _clr_err   = ($urandom_range(0, 7) != 0);
      cycle();
    end

    idle();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
